// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU decoder.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_t;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: moves SHIFT_STEP bits per cycle until the captured amount is used up.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN       = alu_pkg::XLEN,
  parameter int SHAMT_W    = $clog2(XLEN),
  parameter int SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  input  alu_op_t            op_in,
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               last,
  output logic [XLEN-1:0]    step_data,
  output logic [XLEN-1:0]    data
);

  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(SHIFT_STEP);

  alu_op_t            op_q;
  logic [SHAMT_W-1:0] remaining;
  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   step_amt;

  // step_data is the value after this cycle's step, so the final step can feed the output directly
  always_comb begin
    rem_ext  = {1'b0, remaining};
    step_amt = (rem_ext > STEP_W) ? STEP_W : rem_ext;
    last     = (rem_ext <= STEP_W);
    case (op_q)
      ALU_SLL: step_data = data << step_amt;
      ALU_SRA: step_data = $unsigned($signed(data) >>> step_amt);
      default: step_data = data >> step_amt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q      <= ALU_SRL;
      remaining <= '0;
      data      <= '0;
    end else if (start) begin
      op_q      <= op_in;
      remaining <= shamt;
      data      <= data_in;
    end else if (advance) begin
      data      <= step_data;
      remaining <= remaining - step_amt[SHAMT_W-1:0];
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops plus an iterative shifter, registered result with valid/ready.
// state | meaning: IDLE accept ops | SHIFT iterating a shift | HOLD shift done, waiting for output slot
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN       = alu_pkg::XLEN,
  parameter int SHAMT_W    = $clog2(XLEN),
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;

  state_t             state_q, state_d;
  alu_op_t            op;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    single_res;
  logic [XLEN-1:0]    load_val;
  logic [XLEN-1:0]    sh_step_data, sh_data;
  logic               slot_free, load, sh_start, sh_adv, sh_last;

  assign op        = alu_op_t'(ALUControl);
  assign shamt     = SrcB[SHAMT_W-1:0];
  assign slot_free = !out_valid || out_ready;

  // Shift codes land here only with shamt == 0, where the result is SrcA unchanged
  always_comb begin
    single_res = '0;
    case (op)
      ALU_ADD:  single_res = SrcA + SrcB;
      ALU_SUB:  single_res = SrcA - SrcB;
      ALU_AND:  single_res = SrcA & SrcB;
      ALU_OR:   single_res = SrcA | SrcB;
      ALU_XOR:  single_res = SrcA ^ SrcB;
      ALU_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU: single_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      ALU_SLL, ALU_SRL, ALU_SRA: single_res = SrcA;
      default:  single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    load     = 1'b0;
    load_val = single_res;
    sh_start = 1'b0;
    sh_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          if (is_shift_op(op) && (shamt != '0)) begin
            sh_start = 1'b1;
            state_d  = ST_SHIFT;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        sh_adv = 1'b1;
        if (sh_last) begin
          if (slot_free) begin
            load     = 1'b1;
            load_val = sh_step_data;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          load     = 1'b1;
          load_val = sh_data;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_valid <= 1'b1;
        ALUResult <= load_val;
        Zero      <= (load_val == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  alu_shift_iter #(
    .XLEN       (XLEN),
    .SHAMT_W    (SHAMT_W),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .start     (sh_start),
    .advance   (sh_adv),
    .op_in     (op),
    .data_in   (SrcA),
    .shamt     (shamt),
    .last      (sh_last),
    .step_data (sh_step_data),
    .data      (sh_data)
  );

endmodule

// File: tb/tb_alu_exec.sv
// Directed scoreboard bench for alu_exec (SHIFT_STEP=1 main instance, SHIFT_STEP=8 side instance).
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_valid8 = 1'b0;
  logic        in_ready, in_ready8;
  logic [3:0]  ALUControl = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        out_valid, out_valid8;
  logic        out_ready = 1'b0;
  logic        out_ready8 = 1'b1;
  logic [31:0] ALUResult, ALUResult8;
  logic        Zero, Zero8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_exec dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  alu_exec #(.SHIFT_STEP(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid8), .out_ready(out_ready8), .ALUResult(ALUResult8), .Zero(Zero8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard consumer: every handed-off result must match the oldest expectation
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      chk("sb_expected_pending", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("sb_result", ALUResult, e);
        chk("sb_zero", Zero, (e == 32'd0));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present an op (left valid) and return 1 ns after the edge that accepted it
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    sb.push_back(model(op, a, b));
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input string tag, input int lat);
    int n;
    logic busy_ok;
    n = 1; busy_ok = 1'b1;
    while (!out_valid && n < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    if (lat > 1) chk({tag, "_in_ready_low"}, busy_ok, 1);
  endtask

  initial begin
    int c0, n;
    logic stable;

    // reset state
    idle(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_out_valid8", out_valid8, 0);
    reset = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    // 1: wrap into sign bit
    out_ready = 1'b1;
    issue(4'd0, 32'h7FFFFFFF, 32'h1);
    in_valid = 1'b0;
    wait_out("add", 1);
    idle(2);

    // 2: back-to-back single-cycle ops, including unused codes
    c0 = cyc;
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd5, 32'hFFFFFFFF, 32'h1);
    issue(4'd6, 32'hFFFFFFFF, 32'h1);
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
    issue(4'd3, 32'hF000_0001, 32'h0000_1110);
    issue(4'd4, 32'hAAAA_5555, 32'hFFFF_0000);
    issue(4'd10, 32'h1234_5678, 32'h1);
    issue(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_cycles", cyc - c0, 8);
    in_valid = 1'b0;
    idle(2);

    // 3: long arithmetic shift, 1 bit per cycle then 8 bits per cycle
    issue(4'd9, 32'h8000_0000, 32'd31);
    in_valid = 1'b0;
    wait_out("sra31", 32);
    idle(2);
    ALUControl = 4'd9; SrcA = 32'h8000_0000; SrcB = 32'd31; in_valid8 = 1'b1;
    @(negedge clk);
    chk("s8_in_ready", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 100) begin @(posedge clk); #1; n++; end
    chk("s8_latency", n, 5);
    chk("s8_result", ALUResult8, 32'hFFFF_FFFF);
    chk("s8_zero", Zero8, 0);
    idle(2);

    // 4: shift amount from low bits only; zero amount is single-cycle
    issue(4'd7, 32'h1, 32'h25);
    in_valid = 1'b0;
    wait_out("sll5", 6);
    idle(1);
    issue(4'd8, 32'hF000_0000, 32'h124);
    in_valid = 1'b0;
    wait_out("srl4", 5);
    idle(1);
    issue(4'd7, 32'h0000_ABCD, 32'h20);
    in_valid = 1'b0;
    wait_out("sll0", 1);
    idle(2);

    // 5: backpressure holds the result, release allows same-cycle accept
    out_ready = 1'b0;
    issue(4'd0, 32'h10, 32'h2);
    in_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(out_valid === 1'b1 && ALUResult === 32'h12 && Zero === 1'b0 && in_ready === 1'b0))
        stable = 1'b0;
      @(posedge clk); #1;
    end
    chk("hold_stable", stable, 1);
    out_ready = 1'b1;
    c0 = cyc;
    issue(4'd0, 32'd3, 32'd4);
    chk("release_same_cycle", cyc - c0, 1);
    in_valid = 1'b0;
    wait_out("after_release", 1);
    idle(2);

    // 6: reset during a shift discards it
    issue(4'd8, 32'hF000_0000, 32'd20);
    in_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    sb.delete();
    reset = 1'b1;
    idle(30);
    issue(4'd0, 32'd100, 32'd23);
    in_valid = 1'b0;
    wait_out("post_midrst", 1);
    idle(3);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
